facto_host_master: RTL and testbench
====================================

Name: facto_host_master

Overview:
- Bus initiator that drives the factorial subsystem from the master side of its shared bus.
- On `start`, it walks a table of 64-bit operands in RAM. For each operand it programs the factorial core, waits for completion, and writes the 128-bit result back to RAM.
- Occupies the `m_*` master port of the subsystem top and consumes its `interrupt` output.

Parameters:
- FC_BASE, 16'h7000, factorial core register base.
- Core register offsets (fixed): opstart +0x00, opclear +0x08, opdone +0x10, intrEn +0x18, operand +0x20, result_h +0x28, result_l +0x30.
- MAX_CNT_W, 8, width of the operand count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job when idle.
- src_addr  in  16  RAM byte address of the first operand; 8-byte aligned.
- dst_addr  in  16  RAM byte address of the first result; 16 bytes per result.
- count  in  MAX_CNT_W  number of operands; 0 means no work.
- busy  out  1  high from the start-accept cycle to the done cycle.
- done  out  1  one-cycle pulse when the job completes.
- m_req  out  1  bus request.
- m_wr  out  1  1 = write, 0 = read.
- m_addr  out  16  bus byte address.
- m_dout  out  64  write data to the bus.
- m_grant  in  1  bus grant.
- m_din  in  64  read data from the bus.
- interrupt  in  1  factorial core completion (level).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - busy, done, m_req, m_wr = 0; m_addr, m_dout = 0.
  - Internal index, pointers and operand register cleared.
- start and count latching:
  - start is ignored unless in IDLE.
  - src_addr, dst_addr and count are latched on acceptance.
  - count=0 goes directly to DONE; done pulses 1 cycle after start.
- Bus rules:
  - m_req is held high from REQ until the end of a transaction group.
  - No bus access (m_wr/m_addr valid) is issued until m_grant=1 has been sampled.
  - One access per cycle while granted.
  - Read data on m_din is sampled exactly 1 cycle after the read address is presented.
  - If m_grant drops mid-group, the pending access stalls and is re-issued unchanged once grant returns.
- State machine:
  - IDLE -> REQ on accepted start (count≠0).
  - REQ: m_req=1; on m_grant -> RD_OP.
  - RD_OP: read at src_addr + 8·i -> RD_WAIT.
  - RD_WAIT: latch m_din into the operand register -> WR_IEN.
  - WR_IEN: write 1 to FC_BASE+0x18 -> WR_OPND.
  - WR_OPND: write the operand to +0x20 -> WR_GO.
  - WR_GO: write 1 to +0x00 -> WAIT_INT.
  - WAIT_INT:
    - m_req=0 (bus released).
    - On interrupt=1 -> REQ2.
    - The core may finish in 1 cycle (operand 0 or 1); interrupt already high on WAIT_INT entry is accepted.
  - REQ2: m_req=1; on grant -> RD_RH.
  - RD_RH: read +0x28; data is captured in the next cycle while RD_RL issues.
  - RD_RL: read +0x30; data captured in the next cycle.
  - WR_DH: write result_h to dst_addr + 16·i.
  - WR_DL: write result_l to dst_addr + 16·i + 8.
  - WR_CLR: write 1 to +0x08.
  - NEXT: m_req=0; i=i+1; if i==count -> DONE else REQ.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
- Write data: m_dout carries the 64-bit value on write cycles; it is 0 on read cycles.
- Address arithmetic:
  - Modulo 2^16; wrap-around is silent.
  - Pointers advance per operand, not per state.
- Mid-operation reset: abandons the job in the next cycle; m_req drops at once; the core is not cleared.
- busy stays high through WAIT_INT.

Optional Feature:
- Macro FACTO_POLL_EN.
- Defined:
  - WR_IEN writes 0 (interrupt disabled).
  - interrupt is ignored.
  - WAIT_INT keeps the bus and reads opdone (+0x10) every 2 cycles.
  - Bit0=1 -> RD_RH without re-arbitration.
- Undefined: interrupt-driven flow as above.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> busy=0, m_req=0, done=0; no bus access.
- Single job (src=0x0000, dst=0x0100, count=1, RAM[0]=5):
  - Bus writes 1@0x7018, 5@0x7020, 1@0x7000.
  - After interrupt: reads 0x7028 then 0x7030.
  - RAM[0x0100]=0, RAM[0x0108]=120, then 1@0x7008; done pulse.
- Three operands {0,1,20} -> results {0,1},{0,1},{0,0x21C3677C82B40000}; done after the third clear.
- Grant withheld 4 cycles in REQ and dropped 2 cycles during WR_OPND -> no access while m_grant=0; WR_OPND re-issued with identical address and data.
- count=0 -> done 1 cycle after start, no m_req. A start pulsed while busy is ignored.
- Reset asserted during WAIT_INT -> IDLE next cycle, m_req=0. A fresh job afterwards completes correctly.

Source files
------------

// File: rtl/facto_host_master_if.sv
// Master-side shared bus of the factorial subsystem: request/grant handshake,
// one access per granted cycle, read data returned one cycle after the address.
interface facto_host_master_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;

  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              m_grant;
  logic [DATA_W-1:0] m_din;

  modport master (output m_req, m_wr, m_addr, m_dout, input m_grant, m_din);
  modport slave  (input m_req, m_wr, m_addr, m_dout, output m_grant, m_din);
endinterface

// File: rtl/facto_host_master.sv
// Bus initiator: reads 64-bit operands from RAM, runs each through the factorial
// core and writes the 128-bit results back. FACTO_POLL_EN selects opdone polling.
module facto_host_master #(
  parameter logic [15:0] FC_BASE   = 16'h7000,
  parameter int unsigned MAX_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            src_addr,
  input  logic [15:0]            dst_addr,
  input  logic [MAX_CNT_W-1:0]   count,
  output logic                   busy,
  output logic                   done,
  facto_host_master_if.master    bus,
  input  logic                   interrupt
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;

  localparam logic [ADDR_W-1:0] OFS_START = 16'h0000;
  localparam logic [ADDR_W-1:0] OFS_CLEAR = 16'h0008;
  localparam logic [ADDR_W-1:0] OFS_IEN   = 16'h0018;
  localparam logic [ADDR_W-1:0] OFS_OPND  = 16'h0020;
  localparam logic [ADDR_W-1:0] OFS_RESH  = 16'h0028;
  localparam logic [ADDR_W-1:0] OFS_RESL  = 16'h0030;
`ifdef FACTO_POLL_EN
  localparam logic [ADDR_W-1:0] OFS_DONE  = 16'h0010;
  localparam logic [DATA_W-1:0] IEN_VAL   = 64'd0;
`else
  localparam logic [DATA_W-1:0] IEN_VAL   = 64'd1;
`endif

  typedef enum logic [3:0] {
    IDLE, REQ, RD_OP, RD_WAIT, WR_IEN, WR_OPND, WR_GO, WAIT_INT,
    REQ2, RD_RH, RD_RL, WR_DH, WR_DL, WR_CLR, NEXT, DONE
  } state_t;

  state_t                state, state_n;
  logic [ADDR_W-1:0]     src_ptr, src_n, dst_ptr, dst_n;
  logic [MAX_CNT_W-1:0]  cnt, cnt_n, idx, idx_n;
  logic [DATA_W-1:0]     operand, operand_n, res_h, res_h_n, res_l, res_l_n;
  logic                  cap_h, cap_h_n, cap_l, cap_l_n;
  logic                  busy_n, done_n, req_n, wr_n;
  logic [ADDR_W-1:0]     addr_n;
  logic [DATA_W-1:0]     dout_n;
`ifdef FACTO_POLL_EN
  logic                  poll_ph, poll_ph_n;
  logic                  unused_interrupt;
  assign unused_interrupt = interrupt;
`endif

  // Next state, datapath updates, then registered bus outputs decoded from the next state
  always_comb begin
    state_n   = state;
    src_n     = src_ptr;
    dst_n     = dst_ptr;
    cnt_n     = cnt;
    idx_n     = idx;
    operand_n = operand;
    res_h_n   = cap_h ? bus.m_din : res_h;
    res_l_n   = cap_l ? bus.m_din : res_l;
    cap_h_n   = 1'b0;
    cap_l_n   = 1'b0;
`ifdef FACTO_POLL_EN
    poll_ph_n = poll_ph;
`endif
    case (state)
      IDLE: if (start) begin
        src_n   = src_addr;
        dst_n   = dst_addr;
        cnt_n   = count;
        idx_n   = '0;
        state_n = (count == '0) ? DONE : REQ;
      end
      REQ:      if (bus.m_grant) state_n = RD_OP;
      RD_OP:    if (bus.m_grant) state_n = RD_WAIT;
      RD_WAIT: begin
        operand_n = bus.m_din;
        state_n   = WR_IEN;
      end
      WR_IEN:   if (bus.m_grant) state_n = WR_OPND;
      WR_OPND:  if (bus.m_grant) state_n = WR_GO;
      WR_GO: if (bus.m_grant) begin
        state_n = WAIT_INT;
`ifdef FACTO_POLL_EN
        poll_ph_n = 1'b0;
`endif
      end
`ifdef FACTO_POLL_EN
      // Poll phase 0 issues the opdone read, phase 1 inspects the returned data
      WAIT_INT: if (!poll_ph) begin
        if (bus.m_grant) poll_ph_n = 1'b1;
      end else begin
        poll_ph_n = 1'b0;
        if (bus.m_din[0]) state_n = RD_RH;
      end
`else
      WAIT_INT: if (interrupt) state_n = REQ2;
`endif
      REQ2:     if (bus.m_grant) state_n = RD_RH;
      RD_RH: if (bus.m_grant) begin
        cap_h_n = 1'b1;
        state_n = RD_RL;
      end
      RD_RL: if (bus.m_grant) begin
        cap_l_n = 1'b1;
        state_n = WR_DH;
      end
      WR_DH:    if (bus.m_grant) state_n = WR_DL;
      WR_DL:    if (bus.m_grant) state_n = WR_CLR;
      WR_CLR:   if (bus.m_grant) state_n = NEXT;
      NEXT: begin
        idx_n   = MAX_CNT_W'(idx + MAX_CNT_W'(1));
        src_n   = ADDR_W'(src_ptr + ADDR_W'(8));
        dst_n   = ADDR_W'(dst_ptr + ADDR_W'(16));
        state_n = (idx_n == cnt) ? DONE : REQ;
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase

    busy_n = !(state_n inside {IDLE, DONE});
    done_n = (state_n == DONE);
    req_n  = 1'b0;
    wr_n   = 1'b0;
    addr_n = '0;
    dout_n = '0;
    case (state_n)
      REQ, REQ2, RD_WAIT: req_n = 1'b1;
      RD_OP: begin req_n = 1'b1; addr_n = src_n; end
      RD_RH: begin req_n = 1'b1; addr_n = ADDR_W'(FC_BASE + OFS_RESH); end
      RD_RL: begin req_n = 1'b1; addr_n = ADDR_W'(FC_BASE + OFS_RESL); end
      WR_IEN: begin
        req_n = 1'b1; wr_n = 1'b1; addr_n = ADDR_W'(FC_BASE + OFS_IEN); dout_n = IEN_VAL;
      end
      WR_OPND: begin
        req_n = 1'b1; wr_n = 1'b1; addr_n = ADDR_W'(FC_BASE + OFS_OPND); dout_n = operand_n;
      end
      WR_GO: begin
        req_n = 1'b1; wr_n = 1'b1; addr_n = ADDR_W'(FC_BASE + OFS_START); dout_n = 64'd1;
      end
      WR_DH: begin
        req_n = 1'b1; wr_n = 1'b1; addr_n = dst_n; dout_n = res_h_n;
      end
      WR_DL: begin
        req_n = 1'b1; wr_n = 1'b1; addr_n = ADDR_W'(dst_n + ADDR_W'(8)); dout_n = res_l_n;
      end
      WR_CLR: begin
        req_n = 1'b1; wr_n = 1'b1; addr_n = ADDR_W'(FC_BASE + OFS_CLEAR); dout_n = 64'd1;
      end
`ifdef FACTO_POLL_EN
      WAIT_INT: begin
        req_n = 1'b1;
        if (!poll_ph_n) addr_n = ADDR_W'(FC_BASE + OFS_DONE);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      cnt        <= '0;
      idx        <= '0;
      operand    <= '0;
      res_h      <= '0;
      res_l      <= '0;
      cap_h      <= 1'b0;
      cap_l      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bus.m_req  <= 1'b0;
      bus.m_wr   <= 1'b0;
      bus.m_addr <= '0;
      bus.m_dout <= '0;
`ifdef FACTO_POLL_EN
      poll_ph    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      src_ptr    <= src_n;
      dst_ptr    <= dst_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      operand    <= operand_n;
      res_h      <= res_h_n;
      res_l      <= res_l_n;
      cap_h      <= cap_h_n;
      cap_l      <= cap_l_n;
      busy       <= busy_n;
      done       <= done_n;
      bus.m_req  <= req_n;
      bus.m_wr   <= wr_n;
      bus.m_addr <= addr_n;
      bus.m_dout <= dout_n;
`ifdef FACTO_POLL_EN
      poll_ph    <= poll_ph_n;
`endif
    end
  end
endmodule

// File: tb/tb_facto_host_master.sv
// Bench for facto_host_master: RAM + factorial-core bus slave, table of jobs,
// plus hand sequences for reset, count=0, grant stalls and mid-job reset.
module tb_facto_host_master;
  logic        clk = 1'b0;
  logic        reset_n, start, busy, done, interrupt;
  logic [15:0] src_addr, dst_addr;
  logic [7:0]  count;

  always #5 clk = ~clk;

  facto_host_master_if bus ();

  facto_host_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master),
    .interrupt (interrupt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus slave: 64 KiB RAM with the factorial core mapped at 0x7000..0x703F
  logic [63:0]  mem [0:8191];
  logic [63:0]  core_op   = '0;
  logic         core_ien  = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_res  = '0;
  int           core_cnt  = 0;
  int           lat       = 1;

  typedef struct packed { logic [15:0] addr; logic [63:0] data; } acc_t;
  acc_t        wlog[$];
  logic [15:0] rlog[$];

  assign interrupt = core_done & core_ien;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (int k = 2; k <= 34; k++)
      if (64'(k) <= n) r = r * 128'(k);
    return r;
  endfunction

  function automatic logic [63:0] bus_rd(input logic [15:0] a);
    if (a[15:6] == 10'h1C0) begin
      case (a[5:0])
        6'h10:   return {63'd0, core_done};
        6'h18:   return {63'd0, core_ien};
        6'h20:   return core_op;
        6'h28:   return core_res[127:64];
        6'h30:   return core_res[63:0];
        default: return 64'd0;
      endcase
    end
    return mem[a[15:3]];
  endfunction

  always @(posedge clk) begin
    bus.m_din <= bus_rd(bus.m_addr);
    if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_done <= 1'b1;
    end
    if (reset_n && bus.m_req && bus.m_grant) begin
      if (bus.m_wr) begin
        wlog.push_back({bus.m_addr, bus.m_dout});
        if (bus.m_addr[15:6] == 10'h1C0) begin
          case (bus.m_addr[5:0])
            6'h00: if (bus.m_dout[0]) begin
              core_res  <= fact(core_op);
              core_cnt  <= lat;
              core_done <= (lat == 0);
            end
            6'h08: if (bus.m_dout[0]) core_done <= 1'b0;
            6'h18: core_ien <= bus.m_dout[0];
            6'h20: core_op  <= bus.m_dout;
            default: ;
          endcase
        end else begin
          mem[bus.m_addr[15:3]] = bus.m_dout;
        end
      end else if (bus.m_addr == 16'h7028 || bus.m_addr == 16'h7030) begin
        rlog.push_back(bus.m_addr);
      end
    end
  end

  typedef struct {
    logic [15:0]      src;
    logic [15:0]      dst;
    logic [7:0]       cnt;
    int               lat;
    logic [3:0][63:0] op;
    logic [3:0][63:0] eh;
    logic [3:0][63:0] el;
  } job_t;

  job_t jobs[3];
  localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic run_job(input int j);
    job_t        jb = jobs[j];
    acc_t        exp_w[$];
    logic [15:0] exp_r[$];
    logic [15:0] a, d;
    logic        got_done = 1'b0;
    logic        busy_ok  = 1'b1;
    wlog.delete();
    rlog.delete();
    lat = jb.lat;
    for (int k = 0; k < int'(jb.cnt); k++) begin
      d = 16'(jb.dst + 16'(16 * k));
      mem[d[15:3]] = SENT;
      d = 16'(d + 16'd8);
      mem[d[15:3]] = SENT;
    end
    for (int k = 0; k < int'(jb.cnt); k++) begin
      a = 16'(jb.src + 16'(8 * k));
      d = 16'(jb.dst + 16'(16 * k));
      mem[a[15:3]] = jb.op[k];
      exp_w.push_back({16'h7018, 64'd1});
      exp_w.push_back({16'h7020, jb.op[k]});
      exp_w.push_back({16'h7000, 64'd1});
      exp_w.push_back({d, jb.eh[k]});
      exp_w.push_back({16'(d + 16'd8), jb.el[k]});
      exp_w.push_back({16'h7008, 64'd1});
      exp_r.push_back(16'h7028);
      exp_r.push_back(16'h7030);
    end
    @(negedge clk);
    src_addr = jb.src; dst_addr = jb.dst; count = jb.cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_addr = 16'hAAAA; dst_addr = 16'h5555; count = 8'hFF;
    check($sformatf("j%0d busy_after_start", j), 64'(busy), 64'd1);
    for (int c = 0; c < 3000; c++) begin
      if (done) begin got_done = 1'b1; break; end
      if (!busy) busy_ok = 1'b0;
      start = (c == 4);
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("j%0d done_seen", j), 64'(got_done), 64'd1);
    check($sformatf("j%0d busy_during_job", j), 64'(busy_ok), 64'd1);
    check($sformatf("j%0d busy_at_done", j), 64'(busy), 64'd0);
    @(negedge clk);
    check($sformatf("j%0d done_one_cycle", j), 64'(done), 64'd0);
    check($sformatf("j%0d write_count", j), 64'(wlog.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < wlog.size(); k++) begin
      check($sformatf("j%0d wr%0d_addr", j, k), 64'(wlog[k].addr), 64'(exp_w[k].addr));
      check($sformatf("j%0d wr%0d_data", j, k), wlog[k].data, exp_w[k].data);
    end
    check($sformatf("j%0d read_count", j), 64'(rlog.size()), 64'(exp_r.size()));
    for (int k = 0; k < exp_r.size() && k < rlog.size(); k++)
      check($sformatf("j%0d rd%0d_addr", j, k), 64'(rlog[k]), 64'(exp_r[k]));
    for (int k = 0; k < int'(jb.cnt); k++) begin
      d = 16'(jb.dst + 16'(16 * k));
      check($sformatf("j%0d ram_res%0d_h", j, k), mem[d[15:3]], jb.eh[k]);
      d = 16'(d + 16'd8);
      check($sformatf("j%0d ram_res%0d_l", j, k), mem[d[15:3]], jb.el[k]);
    end
  endtask

  // Withhold grant in REQ, then drop it for two cycles on the operand write
  task automatic grant_script();
    logic        found = 1'b0;
    logic [15:0] sa;
    logic [63:0] sd;
    bus.m_grant = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.m_req) begin found = 1'b1; break; end
    end
    check("stall req_seen", 64'(found), 64'd1);
    for (int c = 0; c < 4; c++) begin
      check("stall no_access_wr", 64'(bus.m_wr), 64'd0);
      check("stall req_held", 64'(bus.m_req), 64'd1);
      @(negedge clk);
    end
    bus.m_grant = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.m_wr && bus.m_addr == 16'h7020) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("stall opnd_seen", 64'(found), 64'd1);
    sa = bus.m_addr;
    sd = bus.m_dout;
    bus.m_grant = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall hold_addr", 64'(bus.m_addr), 64'(sa));
      check("stall hold_data", bus.m_dout, sd);
      check("stall hold_wr", 64'(bus.m_wr), 64'd1);
    end
    bus.m_grant = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      jobs[i].op = '0; jobs[i].eh = '0; jobs[i].el = '0;
    end
    jobs[0].src = 16'h0000; jobs[0].dst = 16'h0100; jobs[0].cnt = 8'd1; jobs[0].lat = 3;
    jobs[0].op[0] = 64'd5;  jobs[0].el[0] = 64'd120;
    jobs[1].src = 16'h0200; jobs[1].dst = 16'h0300; jobs[1].cnt = 8'd3; jobs[1].lat = 0;
    jobs[1].op[0] = 64'd0;  jobs[1].el[0] = 64'd1;
    jobs[1].op[1] = 64'd1;  jobs[1].el[1] = 64'd1;
    jobs[1].op[2] = 64'd20; jobs[1].el[2] = 64'h21C3_677C_82B4_0000;
    jobs[2].src = 16'hFFF8; jobs[2].dst = 16'hFFF0; jobs[2].cnt = 8'd2; jobs[2].lat = 5;
    jobs[2].op[0] = 64'd21; jobs[2].eh[0] = 64'd2; jobs[2].el[0] = 64'hC507_7D36_B8C4_0000;
    jobs[2].op[1] = 64'd3;  jobs[2].el[1] = 64'd6;

    for (int i = 0; i < 8192; i++) mem[i] = '0;
    reset_n = 1'b0; start = 1'b1; count = 8'd1; src_addr = '0; dst_addr = 16'h0100;
    bus.m_grant = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset m_req", 64'(bus.m_req), 64'd0);
      check("reset done", 64'(done), 64'd0);
    end
    check("reset m_addr", 64'(bus.m_addr), 64'd0);
    check("reset no_writes", 64'(wlog.size()), 64'd0);
    reset_n = 1'b1; start = 1'b0;

    for (int j = 0; j < 3; j++) run_job(j);

    // count = 0 completes without touching the bus
    wlog.delete();
    @(negedge clk);
    count = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cnt0 done", 64'(done), 64'd1);
    check("cnt0 m_req", 64'(bus.m_req), 64'd0);
    check("cnt0 busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("cnt0 done_cleared", 64'(done), 64'd0);
    check("cnt0 no_writes", 64'(wlog.size()), 64'd0);

    fork
      run_job(0);
      grant_script();
    join

    // Reset while waiting on the core, then a fresh job
    lat = 40;
    wlog.delete();
    mem[0] = 64'd5;
    @(negedge clk);
    src_addr = 16'h0000; dst_addr = 16'h0100; count = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && wlog.size() < 3; c++) @(negedge clk);
    check("midrst reached_wait", 64'(wlog.size()), 64'd3);
    @(negedge clk);
    check("midrst wait_busy", 64'(busy), 64'd1);
    check("midrst wait_req", 64'(bus.m_req), 64'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst m_req", 64'(bus.m_req), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst m_wr", 64'(bus.m_wr), 64'd0);
    reset_n = 1'b1;
    run_job(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
